// File: rtl/csr_exec_unit_pkg.sv
// Shared CSR constants, opcode enum, response payload and read-modify-write helper for csr_exec_unit.
package csr_exec_unit_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned CSR_OP_WIDTH = 3;
   localparam int unsigned CSR_ADDR_W   = 12;

   typedef enum logic [CSR_OP_WIDTH-1:0] {
      CSR_OP_NA = 3'd0,
      CSRRW     = 3'd1,
      CSRRS     = 3'd2,
      CSRRC     = 3'd3,
      CSRRWI    = 3'd5,
      CSRRSI    = 3'd6,
      CSRRCI    = 3'd7
   } csr_op_e;

   localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS       = 12'h300;
   localparam logic [CSR_ADDR_W-1:0] CSR_MISA          = 12'h301;
   localparam logic [CSR_ADDR_W-1:0] CSR_MIE           = 12'h304;
   localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC         = 12'h305;
   localparam logic [CSR_ADDR_W-1:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [CSR_ADDR_W-1:0] CSR_MEPC          = 12'h341;
   localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE        = 12'h342;
   localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL         = 12'h343;
   localparam logic [CSR_ADDR_W-1:0] CSR_MIP           = 12'h344;
   localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE         = 12'hC00;
   localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET       = 12'hC02;
   localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH      = 12'hC82;

   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;
   localparam logic [XLEN-1:0] MIE_MASK     = 32'h0000_0888;
   localparam logic [XLEN-1:0] ALIGN4_MASK  = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [XLEN-1:0] rdata;
      logic            rvalid;
      logic            illegal;
   } csr_rsp_t;

   function automatic logic [XLEN-1:0] csr_alu(input csr_op_e op, input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] src);
      logic [XLEN-1:0] res;
      res = old;
      case (op)
         CSRRW, CSRRWI: res = src;
         CSRRS, CSRRSI: res = old | src;
         CSRRC, CSRRCI: res = old & ~src;
         CSR_OP_NA:     res = old;
         default:       res = old;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independent low/high half writes and an inhibit input.
module csr_counter64
   import csr_exec_unit_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            inc,
   input  logic            inhibit,
   input  logic            wr_lo,
   input  logic            wr_hi,
   input  logic [XLEN-1:0] wdata,
   output logic [63:0]     cnt_o
);

   logic [63:0] cnt_q, cnt_d;
   logic        step;

   // A low-half write swallows that cycle's increment; a high-half write drops the low carry.
   always_comb begin
      cnt_d = cnt_q;
      step  = inc & ~inhibit;
      if (wr_lo) begin
         cnt_d[31:0] = wdata;
      end else if (wr_hi) begin
         cnt_d[63:32] = wdata;
         cnt_d[31:0]  = cnt_q[31:0] + 32'(step);
      end else begin
         cnt_d = cnt_q + 64'(step);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_exec_unit.sv
// Machine-mode CSR file with read-modify-write execution, trap/mret updates and 64-bit counters.
// Optional mcountinhibit CSR is enabled by defining CSR_COUNTER_INHIBIT_EN.
module csr_exec_unit
   import csr_exec_unit_pkg::*;
#(
   parameter logic [31:0] MISA_VAL    = 32'h4000_1100,
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    req,
   input  logic                    csr_we,
   input  logic                    csr_re,
   input  logic [CSR_OP_WIDTH-1:0] csr_op,
   input  logic [11:0]             csr_addr,
   input  logic [31:0]             rs1_data,
   input  logic [4:0]              uimm,
   output logic [31:0]             rdata,
   output logic                    rvalid,
   output logic                    illegal,
   input  logic                    instr_retired,
   input  logic                    trap,
   input  logic [31:0]             trap_pc,
   input  logic [31:0]             trap_cause,
   input  logic [31:0]             trap_val,
   input  logic                    mret,
   input  logic                    irq_ext,
   input  logic                    irq_timer,
   input  logic                    irq_sw,
   output logic [31:0]             mtvec_o,
   output logic [31:0]             mepc_o,
   output logic                    irq_pending
);

   logic            mstatus_mie_q, mstatus_mie_d;
   logic            mstatus_mpie_q, mstatus_mpie_d;
   logic [31:0]     mie_q, mie_d;
   logic [31:0]     mtvec_q, mtvec_d;
   logic [31:0]     mscratch_q, mscratch_d;
   logic [31:0]     mepc_q, mepc_d;
   logic [31:0]     mcause_q, mcause_d;
   logic [31:0]     mtval_q, mtval_d;
   csr_rsp_t        rsp_q, rsp_d;

   logic [63:0]     mcycle, minstret;
   logic            cy_wr_lo_c, cy_wr_hi_c, ir_wr_lo_c, ir_wr_hi_c;
   logic            cy_inhibit_c, ir_inhibit_c;
   logic [31:0]     mip_c, mstatus_c, old_c, src_c, wval_c;
   logic            known_c, illegal_c, wr_en_c;

`ifdef CSR_COUNTER_INHIBIT_EN
   logic            inh_cy_q, inh_cy_d;
   logic            inh_ir_q, inh_ir_d;
   assign cy_inhibit_c = inh_cy_q;
   assign ir_inhibit_c = inh_ir_q;
`else
   assign cy_inhibit_c = 1'b0;
   assign ir_inhibit_c = 1'b0;
`endif

   assign mip_c     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
   assign mstatus_c = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

   // Read mux and address decode.
   always_comb begin
      old_c   = '0;
      known_c = 1'b1;
      case (csr_addr)
         CSR_MSTATUS:   old_c = mstatus_c;
         CSR_MISA:      old_c = MISA_VAL;
         CSR_MIE:       old_c = mie_q;
         CSR_MTVEC:     old_c = mtvec_q;
`ifdef CSR_COUNTER_INHIBIT_EN
         CSR_MCOUNTINHIBIT: old_c = {29'b0, inh_ir_q, 1'b0, inh_cy_q};
`endif
         CSR_MSCRATCH:  old_c = mscratch_q;
         CSR_MEPC:      old_c = mepc_q;
         CSR_MCAUSE:    old_c = mcause_q;
         CSR_MTVAL:     old_c = mtval_q;
         CSR_MIP:       old_c = mip_c;
         CSR_MCYCLE,    CSR_CYCLE:    old_c = mcycle[31:0];
         CSR_MCYCLEH,   CSR_CYCLEH:   old_c = mcycle[63:32];
         CSR_MINSTRET,  CSR_INSTRET:  old_c = minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: old_c = minstret[63:32];
         default:       known_c = 1'b0;
      endcase
   end

   assign illegal_c = req & (~known_c | (csr_we & (csr_addr[11:10] == 2'b11)));
   assign wr_en_c   = req & csr_we & ~illegal_c;
   assign src_c     = csr_op[2] ? {27'b0, uimm} : rs1_data;
   assign wval_c    = csr_alu(csr_op_e'(csr_op), old_c, src_c);

   assign cy_wr_lo_c = wr_en_c & (csr_addr == CSR_MCYCLE);
   assign cy_wr_hi_c = wr_en_c & (csr_addr == CSR_MCYCLEH);
   assign ir_wr_lo_c = wr_en_c & (csr_addr == CSR_MINSTRET);
   assign ir_wr_hi_c = wr_en_c & (csr_addr == CSR_MINSTRETH);

   // Next state: CSR write first, then mret, then trap, so later assignments win per field.
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
`ifdef CSR_COUNTER_INHIBIT_EN
      inh_cy_d       = inh_cy_q;
      inh_ir_d       = inh_ir_q;
`endif
      if (wr_en_c) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mstatus_mie_d  = wval_c[MSTATUS_MIE_BIT];
               mstatus_mpie_d = wval_c[MSTATUS_MPIE_BIT];
            end
            CSR_MIE:      mie_d      = wval_c & MIE_MASK;
            CSR_MTVEC:    mtvec_d    = wval_c & ALIGN4_MASK;
`ifdef CSR_COUNTER_INHIBIT_EN
            CSR_MCOUNTINHIBIT: begin
               inh_cy_d = wval_c[0];
               inh_ir_d = wval_c[2];
            end
`endif
            CSR_MSCRATCH: mscratch_d = wval_c;
            CSR_MEPC:     mepc_d     = wval_c & ALIGN4_MASK;
            CSR_MCAUSE:   mcause_d   = wval_c;
            CSR_MTVAL:    mtval_d    = wval_c;
            default: ;
         endcase
      end
      if (mret) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end
      if (trap) begin
         mepc_d         = trap_pc & ALIGN4_MASK;
         mcause_d       = trap_cause;
         mtval_d        = trap_val;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end
      rsp_d.rvalid  = req;
      rsp_d.illegal = illegal_c;
      rsp_d.rdata   = (req & csr_re & ~illegal_c) ? old_c : '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= RESET_MTVEC;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         rsp_q          <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         rsp_q          <= rsp_d;
      end
   end

`ifdef CSR_COUNTER_INHIBIT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inh_cy_q <= 1'b0;
         inh_ir_q <= 1'b0;
      end else begin
         inh_cy_q <= inh_cy_d;
         inh_ir_q <= inh_ir_d;
      end
   end
`endif

   csr_counter64 u_mcycle (
      .clk     (clk),
      .resetn  (resetn),
      .inc     (1'b1),
      .inhibit (cy_inhibit_c),
      .wr_lo   (cy_wr_lo_c),
      .wr_hi   (cy_wr_hi_c),
      .wdata   (wval_c),
      .cnt_o   (mcycle)
   );

   csr_counter64 u_minstret (
      .clk     (clk),
      .resetn  (resetn),
      .inc     (instr_retired),
      .inhibit (ir_inhibit_c),
      .wr_lo   (ir_wr_lo_c),
      .wr_hi   (ir_wr_hi_c),
      .wdata   (wval_c),
      .cnt_o   (minstret)
   );

   assign rdata       = rsp_q.rdata;
   assign rvalid      = rsp_q.rvalid;
   assign illegal     = rsp_q.illegal;
   assign mtvec_o     = mtvec_q;
   assign mepc_o      = mepc_q;
   assign irq_pending = (|(mip_c & mie_q)) & mstatus_mie_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed self-checking bench for csr_exec_unit; honours CSR_COUNTER_INHIBIT_EN when defined.
module tb_csr_exec_unit;

   localparam logic [2:0] OP_RW = 3'd1, OP_RS = 3'd2, OP_RC = 3'd3;
   localparam logic [2:0] OP_RSI = 3'd6, OP_RCI = 3'd7;

   logic        clk = 1'b0;
   logic        resetn, req, csr_we, csr_re;
   logic [2:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] rs1_data;
   logic [4:0]  uimm;
   logic [31:0] rdata;
   logic        rvalid, illegal;
   logic        instr_retired, trap, mret;
   logic [31:0] trap_pc, trap_cause, trap_val;
   logic        irq_ext, irq_timer, irq_sw;
   logic [31:0] mtvec_o, mepc_o;
   logic        irq_pending;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] rd;
   logic        rv, il;

   always #5 clk = ~clk;

   csr_exec_unit dut (
      .clk(clk), .resetn(resetn), .req(req), .csr_we(csr_we), .csr_re(csr_re),
      .csr_op(csr_op), .csr_addr(csr_addr), .rs1_data(rs1_data), .uimm(uimm),
      .rdata(rdata), .rvalid(rvalid), .illegal(illegal),
      .instr_retired(instr_retired), .trap(trap), .trap_pc(trap_pc),
      .trap_cause(trap_cause), .trap_val(trap_val), .mret(mret),
      .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
      .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_pending(irq_pending)
   );

   // Called 1 time unit after a rising edge; issues one request and samples the response.
   task automatic do_csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [4:0] imm, input logic we, input logic re,
                         output logic [31:0] o_rd, output logic o_rv, output logic o_il);
      req = 1'b1; csr_op = op; csr_addr = addr; rs1_data = rs1; uimm = imm;
      csr_we = we; csr_re = re;
      @(posedge clk); #1;
      o_rd = rdata; o_rv = rvalid; o_il = illegal;
      req = 1'b0; csr_we = 1'b0; csr_re = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %h want 0", rvalid); end
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
      n_checks++; if (mtvec_o !== 32'h0) begin n_fail++; $display("FAIL reset_mtvec got %h want 0", mtvec_o); end
      n_checks++; if (mepc_o !== 32'h0) begin n_fail++; $display("FAIL reset_mepc got %h want 0", mepc_o); end
      n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %h want 0", irq_pending); end
      resetn = 1'b1;
      idle(1);
   endtask

   task automatic test_mscratch();
      do_csr(OP_RW, 12'h340, 32'hDEADBEEF, 5'd0, 1'b1, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mscratch_first got %h want 0", rd); end
      n_checks++; if (rv !== 1'b1) begin n_fail++; $display("FAIL mscratch_rvalid got %h want 1", rv); end
      do_csr(OP_RS, 12'h340, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mscratch_read got %h want deadbeef", rd); end
      idle(1);
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse got %h want 0", rvalid); end
      do_csr(OP_RS, 12'h340, 32'h0, 5'd0, 1'b0, 1'b0, rd, rv, il);
      n_checks++; if (rd !== 32'h0 || rv !== 1'b1) begin n_fail++; $display("FAIL noop_req got rd=%h rv=%h want 0/1", rd, rv); end
      do_csr(OP_RS, 12'h340, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mscratch_kept got %h want deadbeef", rd); end
   endtask

   task automatic test_mstatus_misa_mtvec();
      do_csr(OP_RSI, 12'h300, 32'h0, 5'h8, 1'b1, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mstatus_rsi got %h want 0", rd); end
      do_csr(OP_RCI, 12'h300, 32'h0, 5'h8, 1'b1, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL mstatus_rci got %h want 8", rd); end
      do_csr(OP_RW, 12'h300, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mstatus_cleared got %h want 0", rd); end
      do_csr(OP_RS, 12'h300, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h88) begin n_fail++; $display("FAIL mstatus_mask got %h want 88", rd); end
      do_csr(OP_RW, 12'h300, 32'h0, 5'd0, 1'b1, 1'b0, rd, rv, il);
      do_csr(OP_RW, 12'h301, 32'h0, 5'd0, 1'b1, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h40001100 || il !== 1'b0) begin n_fail++; $display("FAIL misa_write got rd=%h il=%h want 40001100/0", rd, il); end
      do_csr(OP_RS, 12'h301, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h40001100) begin n_fail++; $display("FAIL misa_ro got %h want 40001100", rd); end
      do_csr(OP_RW, 12'h305, 32'h12345677, 5'd0, 1'b1, 1'b0, rd, rv, il);
      n_checks++; if (mtvec_o !== 32'h12345674) begin n_fail++; $display("FAIL mtvec_align got %h want 12345674", mtvec_o); end
   endtask

   task automatic test_mcycle();
      do_csr(OP_RW, 12'hB00, 32'hFFFFFFFE, 5'd0, 1'b1, 1'b0, rd, rv, il);
      do_csr(OP_RW, 12'hB80, 32'h0, 5'd0, 1'b1, 1'b0, rd, rv, il);
      idle(3);
      do_csr(OP_RS, 12'hB80, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL mcycleh_carry got %h want 1", rd); end
      do_csr(OP_RS, 12'hB00, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL mcycle_wrap got %h want 3", rd); end
      do_csr(OP_RW, 12'hC00, 32'h12345678, 5'd0, 1'b1, 1'b1, rd, rv, il);
      n_checks++; if (il !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL cycle_ro_write got il=%h rd=%h want 1/0", il, rd); end
      do_csr(OP_RS, 12'hB00, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL mcycle_after_illegal got %h want 5", rd); end
      do_csr(OP_RS, 12'hC80, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h1 || il !== 1'b0) begin n_fail++; $display("FAIL cycleh_shadow got rd=%h il=%h want 1/0", rd, il); end
   endtask

   task automatic test_minstret();
      instr_retired = 1'b0;
      do_csr(OP_RW, 12'hB02, 32'h0, 5'd0, 1'b1, 1'b0, rd, rv, il);
      do_csr(OP_RW, 12'hB82, 32'h0, 5'd0, 1'b1, 1'b0, rd, rv, il);
      instr_retired = 1'b1; idle(3); instr_retired = 1'b0;
      do_csr(OP_RS, 12'hB02, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL minstret_count got %h want 3", rd); end
      instr_retired = 1'b1;
      do_csr(OP_RW, 12'hB02, 32'd10, 5'd0, 1'b1, 1'b0, rd, rv, il);
      idle(1); instr_retired = 1'b0;
      do_csr(OP_RS, 12'hC02, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'd11) begin n_fail++; $display("FAIL minstret_lo_write_drop got %h want b", rd); end
      do_csr(OP_RW, 12'hB02, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0, rd, rv, il);
      instr_retired = 1'b1;
      do_csr(OP_RW, 12'hB82, 32'h7, 5'd0, 1'b1, 1'b0, rd, rv, il);
      instr_retired = 1'b0;
      do_csr(OP_RS, 12'hB82, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h7) begin n_fail++; $display("FAIL minstreth_no_carry got %h want 7", rd); end
      do_csr(OP_RS, 12'hB02, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL minstret_hi_write_inc got %h want 0", rd); end
   endtask

   task automatic test_trap_mret();
      do_csr(OP_RW, 12'h300, 32'h8, 5'd0, 1'b1, 1'b0, rd, rv, il);
      trap = 1'b1; trap_pc = 32'h80000103; trap_cause = 32'h8000000B; trap_val = 32'h55;
      do_csr(OP_RW, 12'h341, 32'h11111111, 5'd0, 1'b1, 1'b1, rd, rv, il);
      trap = 1'b0;
      n_checks++; if (mepc_o !== 32'h80000100) begin n_fail++; $display("FAIL trap_mepc got %h want 80000100", mepc_o); end
      do_csr(OP_RS, 12'h300, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h80) begin n_fail++; $display("FAIL trap_mstatus got %h want 80", rd); end
      do_csr(OP_RS, 12'h342, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h8000000B) begin n_fail++; $display("FAIL trap_mcause got %h want 8000000b", rd); end
      do_csr(OP_RS, 12'h343, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h55) begin n_fail++; $display("FAIL trap_mtval got %h want 55", rd); end
      mret = 1'b1; idle(1); mret = 1'b0;
      do_csr(OP_RS, 12'h300, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus got %h want 88", rd); end
      trap = 1'b1; trap_pc = 32'h00000200;
      do_csr(OP_RW, 12'h340, 32'hCAFE0000, 5'd0, 1'b1, 1'b0, rd, rv, il);
      trap = 1'b0;
      do_csr(OP_RS, 12'h340, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'hCAFE0000) begin n_fail++; $display("FAIL trap_side_write got %h want cafe0000", rd); end
      trap = 1'b1; mret = 1'b1; trap_pc = 32'h00000404;
      idle(1);
      trap = 1'b0; mret = 1'b0;
      do_csr(OP_RS, 12'h300, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h0 || mepc_o !== 32'h404) begin n_fail++; $display("FAIL trap_over_mret got mstatus=%h mepc=%h want 0/404", rd, mepc_o); end
   endtask

   task automatic test_irq_illegal();
      irq_timer = 1'b1;
      do_csr(OP_RW, 12'h304, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0, rd, rv, il);
      do_csr(OP_RW, 12'h304, 32'h80, 5'd0, 1'b1, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h888) begin n_fail++; $display("FAIL mie_mask got %h want 888", rd); end
      n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_gated got %h want 0", irq_pending); end
      do_csr(OP_RSI, 12'h300, 32'h0, 5'h8, 1'b1, 1'b0, rd, rv, il);
      n_checks++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL irq_pending got %h want 1", irq_pending); end
      do_csr(OP_RCI, 12'h300, 32'h0, 5'h8, 1'b1, 1'b0, rd, rv, il);
      n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_cleared got %h want 0", irq_pending); end
      do_csr(OP_RC, 12'h344, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h80 || il !== 1'b0) begin n_fail++; $display("FAIL mip_read got rd=%h il=%h want 80/0", rd, il); end
      irq_timer = 1'b0;
      do_csr(OP_RS, 12'h7C0, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (il !== 1'b1 || rd !== 32'h0 || rv !== 1'b1) begin n_fail++; $display("FAIL unknown_addr got il=%h rd=%h rv=%h want 1/0/1", il, rd, rv); end
   endtask

   task automatic test_inhibit();
`ifdef CSR_COUNTER_INHIBIT_EN
      do_csr(OP_RW, 12'h320, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h0 || il !== 1'b0) begin n_fail++; $display("FAIL inhibit_init got rd=%h il=%h want 0/0", rd, il); end
      do_csr(OP_RS, 12'h320, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL inhibit_mask got %h want 5", rd); end
      do_csr(OP_RW, 12'hB00, 32'd100, 5'd0, 1'b1, 1'b0, rd, rv, il);
      do_csr(OP_RW, 12'hB02, 32'd200, 5'd0, 1'b1, 1'b0, rd, rv, il);
      instr_retired = 1'b1; idle(10); instr_retired = 1'b0;
      do_csr(OP_RS, 12'hB00, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'd100) begin n_fail++; $display("FAIL mcycle_frozen got %h want 64", rd); end
      do_csr(OP_RS, 12'hB02, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'd200) begin n_fail++; $display("FAIL minstret_frozen got %h want c8", rd); end
      do_csr(OP_RW, 12'h320, 32'h0, 5'd0, 1'b1, 1'b0, rd, rv, il);
`else
      do_csr(OP_RW, 12'h320, 32'h5, 5'd0, 1'b1, 1'b1, rd, rv, il);
      n_checks++; if (il !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL inhibit_absent got il=%h rd=%h want 1/0", il, rd); end
`endif
   endtask

   task automatic test_reset_mid_request();
      req = 1'b1; csr_re = 1'b1; csr_we = 1'b0; csr_op = OP_RS; csr_addr = 12'h340; rs1_data = 32'h0;
      #2 resetn = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mid_req got rv=%h rd=%h want 0/0", rvalid, rdata); end
      req = 1'b0; csr_re = 1'b0;
      resetn = 1'b1;
      idle(1);
      do_csr(OP_RS, 12'h340, 32'h0, 5'd0, 1'b0, 1'b1, rd, rv, il);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mscratch_after_reset got %h want 0", rd); end
   endtask

   initial begin
      resetn = 1'b0; req = 1'b0; csr_we = 1'b0; csr_re = 1'b0; csr_op = 3'd0; csr_addr = 12'h0;
      rs1_data = 32'h0; uimm = 5'd0; instr_retired = 1'b0; trap = 1'b0; mret = 1'b0;
      trap_pc = 32'h0; trap_cause = 32'h0; trap_val = 32'h0;
      irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
      test_reset();
      test_mscratch();
      test_mstatus_misa_mtvec();
      test_mcycle();
      test_minstret();
      test_trap_mret();
      test_irq_illegal();
      test_inhibit();
      test_reset_mid_request();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
